// File: rtl/fibo_result_checker.sv
// Walks N_TERMS data-memory words after a CPU halt edge and checks them against a Fibonacci reference.
// Optional FIBO_CHK_EARLY_STOP_EN: the first mismatching term ends the pass.
module fibo_result_checker #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int N_TERMS     = 20,
  parameter int BASE_ADDR   = 1,
  parameter int ADDR_STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_idx,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              halt_q;
  logic [7:0]        k;
  logic [DATA_W-1:0] prv1, prv2, exp_val;
  logic              start, mismatch, last;

  assign start    = halt & ~halt_q;
  assign exp_val  = (k <= 8'd2) ? DATA_W'(1) : prv1 + prv2;
  assign mismatch = (state == WAIT) && (rd_data != exp_val);
  assign last     = (k == 8'(N_TERMS));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ:  state_nxt = WAIT;
`ifdef FIBO_CHK_EARLY_STOP_EN
      WAIT: state_nxt = (last || mismatch) ? DONE : REQ;
`else
      WAIT: state_nxt = last ? DONE : REQ;
`endif
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      halt_q   <= 1'b0;
      k        <= 8'd0;
      rd_addr  <= '0;
      prv1     <= '0;
      prv2     <= '0;
      err_cnt  <= 8'd0;
      fail_idx <= 8'd0;
    end else begin
      state  <= state_nxt;
      halt_q <= halt;
      if (state == IDLE && start) begin
        k       <= 8'd1;
        rd_addr <= ADDR_W'(BASE_ADDR);
        prv1    <= '0;
        prv2    <= '0;
      end
      if (state == WAIT) begin
        // history advances whether or not the term matched
        prv2 <= prv1;
        prv1 <= exp_val;
        if (state_nxt == REQ) begin
          k       <= k + 8'd1;
          rd_addr <= rd_addr + ADDR_W'(ADDR_STRIDE);
        end
        if (mismatch) begin
          if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
          if (fail_idx == 8'd0) fail_idx <= k;
        end
      end
    end
  end

  assign rd_en = (state == REQ);
  assign busy  = (state == REQ) || (state == WAIT);
  assign done  = (state == DONE);
  assign pass  = (state == DONE) && (err_cnt == 8'd0);

endmodule

// File: tb/tb_fibo_result_checker.sv
// Randomized bench for fibo_result_checker: two configurations against a Fibonacci memory model.
module tb_fibo_result_checker;
  localparam int N0 = 20, B0 = 1, S0 = 1;
  localparam int N1 = 30, B1 = 4, S1 = 3;

  logic clk = 1'b0, rst = 1'b0, halt0 = 1'b0, halt1 = 1'b0;
  always #5 clk = ~clk;

  logic        rd_en0, busy0, done0, pass0;
  logic [63:0] rd_addr0, rd_data0;
  logic [7:0]  fail_idx0, err_cnt0;
  logic        rd_en1, busy1, done1, pass1;
  logic [63:0] rd_addr1;
  logic [15:0] rd_data1;
  logic [7:0]  fail_idx1, err_cnt1;

  fibo_result_checker #(.DATA_W(64), .ADDR_W(64), .N_TERMS(N0), .BASE_ADDR(B0), .ADDR_STRIDE(S0)) dut0 (
    .clk(clk), .rst(rst), .halt(halt0), .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_idx(fail_idx0), .err_cnt(err_cnt0));

  fibo_result_checker #(.DATA_W(16), .ADDR_W(64), .N_TERMS(N1), .BASE_ADDR(B1), .ADDR_STRIDE(S1)) dut1 (
    .clk(clk), .rst(rst), .halt(halt1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_idx(fail_idx1), .err_cnt(err_cnt1));

  logic [63:0] mem0 [0:63];
  logic [15:0] mem1 [0:127];
  logic [63:0] fib0 [1:N0];
  logic [15:0] fib1 [1:N1];

  // 1-cycle read port; garbage when not strobed so stray sampling would show up
  always @(posedge clk) begin
    rd_data0 <= rd_en0 ? mem0[rd_addr0[5:0]] : {$urandom, $urandom};
    rd_data1 <= rd_en1 ? mem1[rd_addr1[6:0]] : 16'($urandom);
  end

  int n_chk = 0, n_fail = 0;
  int last_lat, last_reads;
`ifdef FIBO_CHK_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample(input int d, output logic en, output logic [63:0] addr, output logic bsy,
                        output logic dn, output logic ps, output logic [7:0] fi, output logic [7:0] ec);
    en  = d ? rd_en1 : rd_en0;     addr = d ? rd_addr1 : rd_addr0;
    bsy = d ? busy1 : busy0;       dn   = d ? done1 : done0;
    ps  = d ? pass1 : pass0;       fi   = d ? fail_idx1 : fail_idx0;
    ec  = d ? err_cnt1 : err_cnt0;
  endtask

  task automatic fill_good(input int d);
    if (d == 0) for (int k = 1; k <= N0; k++) mem0[B0 + (k-1)*S0] = fib0[k];
    else        for (int k = 1; k <= N1; k++) mem1[B1 + (k-1)*S1] = fib1[k];
  endtask

  task automatic corrupt(input int d, input int k);
    logic [63:0] x;
    x = {$urandom, $urandom} | 64'h1;
    if (d == 0) mem0[B0 + (k-1)*S0] = mem0[B0 + (k-1)*S0] ^ x;
    else        mem1[B1 + (k-1)*S1] = mem1[B1 + (k-1)*S1] ^ x[15:0];
  endtask

  task automatic model(input int d, output int e_err, output int e_first, output int e_reads);
    int n;
    logic [63:0] w, r;
    n = d ? N1 : N0;
    e_err = 0; e_first = 0;
    for (int k = 1; k <= n; k++) begin
      w = d ? 64'(mem1[B1 + (k-1)*S1]) : mem0[B0 + (k-1)*S0];
      r = d ? 64'(fib1[k]) : fib0[k];
      if (w != r) begin
        if (e_err < 255) e_err++;
        if (e_first == 0) e_first = k;
        if (EARLY) break;
      end
    end
    e_reads = (EARLY && e_first != 0) ? e_first : n;
  endtask

  task automatic do_reset(input logic halt_lvl);
    rst = 1'b0; halt0 = halt_lvl; halt1 = halt_lvl;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // one check pass: per-cycle read/address checks, then final results and post-done stability
  task automatic run_pass(input int d, input bit toggles, input string nm);
    int cyc, reads, n, base, stride, e_err, e_first, e_reads;
    logic en, bsy, dn, ps, dn0, ps0;
    logic [63:0] addr;
    logic [7:0] fi, ec, fi0, ec0;
    bit got;
    n = d ? N1 : N0; base = d ? B1 : B0; stride = d ? S1 : S0;
    model(d, e_err, e_first, e_reads);
    if (d == 0) halt0 = 1'b1; else halt1 = 1'b1;
    cyc = 0; reads = 0; got = 0;
    while (cyc < 400 && !got) begin
      @(posedge clk); #1; cyc++;
      sample(d, en, addr, bsy, dn, ps, fi, ec);
      if (en) begin
        chk({nm, " rd_addr"}, addr, 64'(base + reads*stride));
        chk({nm, " busy_on_rd"}, bsy, 1'b1);
        reads++;
      end
      if (!dn) chk({nm, " pass_before_done"}, ps, 1'b0);
      if (toggles && (cyc % 7 == 3)) begin
        if (d == 0) halt0 = ~halt0; else halt1 = ~halt1;
      end
      got = dn;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no done after %0d cycles", nm, cyc);
    end
    last_lat = cyc; last_reads = reads;
    chk({nm, " latency"}, 64'(cyc), 64'(2*e_reads + 1));
    chk({nm, " reads"}, 64'(reads), 64'(e_reads));
    chk({nm, " busy_done"}, bsy, 1'b0);
    chk({nm, " pass"}, ps, (e_err == 0));
    chk({nm, " fail_idx"}, 64'(fi), 64'(e_first));
    chk({nm, " err_cnt"}, 64'(ec), 64'(e_err));
    dn0 = dn; ps0 = ps; fi0 = fi; ec0 = ec;
    for (int i = 0; i < 8; i++) begin
      if (toggles || i == 2) begin
        if (d == 0) halt0 = ~halt0; else halt1 = ~halt1;
      end
      @(posedge clk); #1;
      sample(d, en, addr, bsy, dn, ps, fi, ec);
      chk({nm, " post_rd_en"}, en, 1'b0);
      chk({nm, " post_state"}, {bsy, dn, ps, fi, ec}, {1'b0, dn0, ps0, fi0, ec0});
    end
    halt0 = 1'b0; halt1 = 1'b0;
  endtask

  initial begin
    logic en, bsy, dn, ps;
    logic [63:0] addr;
    logic [7:0] fi, ec;
    fib0[1] = 64'd1; fib0[2] = 64'd1;
    for (int k = 3; k <= N0; k++) fib0[k] = fib0[k-1] + fib0[k-2];
    fib1[1] = 16'd1; fib1[2] = 16'd1;
    for (int k = 3; k <= N1; k++) fib1[k] = fib1[k-1] + fib1[k-2];
    for (int i = 0; i < 64; i++) mem0[i] = 64'hdead_beef_0000_0000 | 64'(i);
    for (int i = 0; i < 128; i++) mem1[i] = 16'(16'hbe00 | i);
    chk("model_f20", fib0[20], 64'd6765);
    chk("model_f25_mod16", 64'(fib1[25]), 64'd9489);

    // reset state
    #12;
    chk("reset_dut0", {rd_en0, rd_addr0, busy0, done0, pass0, fail_idx0, err_cnt0}, '0);
    chk("reset_dut1", {rd_en1, rd_addr1, busy1, done1, pass1, fail_idx1, err_cnt1}, '0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T1 correct memory
    fill_good(0);
    run_pass(0, 0, "T1");
    chk("T1_lat41", 64'(last_lat), 64'd41);
    chk("T1_reads20", 64'(last_reads), 64'd20);
    chk("T1_result", {pass0, fail_idx0, err_cnt0}, {1'b1, 8'd0, 8'd0});

    // T2 two bad words
    do_reset(1'b0); fill_good(0);
    mem0[7] = 64'd14; mem0[12] = 64'd0;
    run_pass(0, 0, "T2");
    chk("T2_pass", pass0, 1'b0);
    chk("T2_fail_idx", 64'(fail_idx0), 64'd7);
    chk("T2_err_cnt", 64'(err_cnt0), EARLY ? 64'd1 : 64'd2);
    chk("T2_reads", 64'(last_reads), EARLY ? 64'd7 : 64'd20);

    // T3 first and second terms
    do_reset(1'b0); fill_good(0); mem0[1] = 64'd0;
    run_pass(0, 0, "T3a");
    chk("T3a_fail_idx", 64'(fail_idx0), 64'd1);
    do_reset(1'b0); fill_good(0); mem0[2] = 64'd3;
    run_pass(0, 0, "T3b");
    chk("T3b_fail_idx", 64'(fail_idx0), 64'd2);
    chk("T3b_err_cnt", 64'(err_cnt0), 64'd1);

    // T4 abort mid-pass, then fresh pass
    do_reset(1'b0); fill_good(0); mem0[2] = 64'd9;
    halt0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("T4_pre_abort_busy", busy0, 1'b1);
    chk("T4_pre_abort_err", 64'(err_cnt0), 64'd1);
    rst = 1'b0; #1;
    sample(0, en, addr, bsy, dn, ps, fi, ec);
    chk("T4_abort", {en, bsy, dn, ps, fi, ec, addr}, '0);
    halt0 = 1'b0; mem0[2] = fib0[2];
    @(posedge clk); #1; rst = 1'b1;
    run_pass(0, 0, "T4");
    chk("T4_lat41", 64'(last_lat), 64'd41);
    chk("T4_pass", pass0, 1'b1);

    // halt already high when reset releases
    do_reset(1'b1); fill_good(0);
    run_pass(0, 0, "T4b");
    chk("T4b_lat41", 64'(last_lat), 64'd41);

    // T5 halt toggling during busy and after done
    do_reset(1'b0); fill_good(0);
    run_pass(0, 1, "T5");
    chk("T5_reads20", 64'(last_reads), 64'd20);

    // T6 16-bit wrap, 30 terms, strided addresses
    do_reset(1'b0); fill_good(1);
    run_pass(1, 0, "T6");
    chk("T6_pass", pass1, 1'b1);
    chk("T6_lat", 64'(last_lat), 64'd61);

    // randomized corruption on both configurations
    for (int it = 0; it < 12; it++) begin
      int d, nc;
      d = it % 2;
      do_reset(1'b0); fill_good(d);
      nc = $urandom_range(0, 4);
      for (int j = 0; j < nc; j++) corrupt(d, $urandom_range(1, d ? N1 : N0));
      run_pass(d, it % 3 == 0, $sformatf("R%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
